// File: rtl/soc_system_dipsw_debounce_if.sv
// Avalon-MM slave bus bundle for the DIP-switch debounce block.
// Signals:
//   address    word address (2 bits)
//   chipselect slave select
//   write_n    write strobe, active-low
//   writedata  write data (32 bits)
//   readdata   read data (32 bits), returned combinationally
interface soc_system_dipsw_debounce_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_dipsw_debounce.sv
// DIP-switch input conditioner: 2-FF synchroniser, per-bit counter debouncer,
// and edge capture with a maskable level interrupt.
// Ports:
//   clk        system clock
//   reset      synchronous reset, active-high
//   avs        Avalon-MM slave (0: state RO, 1: threshold, 2: mask, 3: edge RW1C)
//   in_port    raw asynchronous switch inputs
//   sw_stable  debounced switch state
//   irq        registered level interrupt, |(edgecapture & mask)
module soc_system_dipsw_debounce #(
  parameter int unsigned           WIDTH       = 4,
  parameter int unsigned           CNT_W       = 20,
  parameter int unsigned           DEB_DEFAULT = 500000,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  soc_system_dipsw_debounce_if.slave  avs,
  input  logic [WIDTH-1:0]            in_port,
  output logic [WIDTH-1:0]            sw_stable,
  output logic                        irq
);

  localparam logic [CNT_W-1:0] THR_RESET = CNT_W'(DEB_DEFAULT);

  logic [WIDTH-1:0] sync0;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] ecap;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] clr;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [CNT_W-1:0] threshold;
  logic [CNT_W-1:0] thr_eff;
  logic             wr;
  logic             unused_wdata;

  assign wr           = avs.chipselect & ~avs.write_n;
  assign sw_stable    = stable;
  assign unused_wdata = ^avs.writedata;

  always_comb begin
    thr_eff = (threshold == '0) ? CNT_W'(1) : threshold;
  end

  // A bit flips once its mismatch has persisted thr_eff cycles. The compare is
  // done one bit wider so a lowered threshold takes effect immediately and the
  // increment can never wrap.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      hit[i] = (sync1[i] != stable[i]) &&
               (({1'b0, cnt[i]} + (CNT_W+1)'(1)) >= {1'b0, thr_eff});
    end
  end

  always_comb begin
    clr = '0;
    if (wr && avs.address == 2'd3) clr = avs.writedata[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0     <= RESET_VALUE;
      sync1     <= RESET_VALUE;
      stable    <= RESET_VALUE;
      threshold <= THR_RESET;
      mask      <= '0;
      ecap      <= '0;
      irq       <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync0 <= in_port;
      sync1 <= sync0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync1[i] == stable[i] || hit[i]) cnt[i] <= '0;
        else                                 cnt[i] <= cnt[i] + 1'b1;
      end
      stable <= stable ^ hit;
      // Set has priority over a same-cycle write-1-to-clear.
      ecap   <= (ecap & ~clr) | hit;
      irq    <= |(ecap & mask);
      if (wr && avs.address == 2'd1) threshold <= avs.writedata[CNT_W-1:0];
      if (wr && avs.address == 2'd2) mask      <= avs.writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    avs.readdata = '0;
    case (avs.address)
      2'd0: avs.readdata[WIDTH-1:0] = stable;
      2'd1: avs.readdata[CNT_W-1:0] = threshold;
      2'd2: avs.readdata[WIDTH-1:0] = mask;
      2'd3: avs.readdata[WIDTH-1:0] = ecap;
      default: avs.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_soc_system_dipsw_debounce.sv
// Testbench for soc_system_dipsw_debounce: stimulus pushes expected values into
// a queue; a negedge monitor pops and compares them against the DUT outputs.
module tb_soc_system_dipsw_debounce;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] in_port = 4'b0000;
  logic [3:0] sw_stable;
  logic       irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    int          kind;   // 0 readdata, 1 sw_stable, 2 irq
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  soc_system_dipsw_debounce_if bus();

  soc_system_dipsw_debounce #(
    .WIDTH(4),
    .CNT_W(20),
    .DEB_DEFAULT(500000),
    .RESET_VALUE(4'b0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .avs(bus),
    .in_port(in_port),
    .sw_stable(sw_stable),
    .irq(irq)
  );

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        0:       act = bus.readdata;
        1:       act = {28'd0, sw_stable};
        default: act = {31'd0, irq};
      endcase
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input int kind, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic rd(input logic [1:0] a, input string name, input logic [31:0] v);
    bus.address    = a;
    bus.chipselect = 1'b1;
    expect_val(name, 0, v);
    tick(1);
    bus.chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick(1);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    tick(3);
    reset = 1'b0;

    // T1: reset state
    expect_val("t1_irq", 2, 0);
    expect_val("t1_sw", 1, 0);
    rd(2'd0, "t1_data", 0);
    rd(2'd1, "t1_thr", 500000);
    rd(2'd2, "t1_mask", 0);
    rd(2'd3, "t1_ecap", 0);

    // T2: threshold 4, bit0 rises exactly 6 clocks after in_port changes
    wr(2'd1, 4);
    wr(2'd2, 1);
    in_port = 4'b0001;
    tick(5);
    expect_val("t2_sw_early", 1, 0);
    tick(1);
    expect_val("t2_sw_rise", 1, 1);
    expect_val("t2_irq_same", 2, 0);
    rd(2'd3, "t2_ecap", 1);
    expect_val("t2_irq_next", 2, 1);

    // T3: 3-clock glitch on bit1 is filtered
    in_port = 4'b0011;
    tick(3);
    in_port = 4'b0001;
    tick(6);
    expect_val("t3_sw", 1, 1);
    rd(2'd3, "t3_ecap", 1);

    // T4: RW1C edge capture, irq tracking, set-beats-clear
    in_port = 4'b0011;
    tick(6);
    expect_val("t4_sw", 1, 3);
    rd(2'd3, "t4_ecap3", 3);
    expect_val("t4_irq_set", 2, 1);
    wr(2'd3, 1);
    rd(2'd3, "t4_ecap_clr0", 2);
    expect_val("t4_irq_clr", 2, 0);
    wr(2'd2, 2);
    expect_val("t4_irq_mask_same", 2, 0);
    tick(1);
    expect_val("t4_irq_mask_next", 2, 1);
    in_port = 4'b0001;
    tick(5);
    wr(2'd3, 2);
    expect_val("t4_sw_fall", 1, 1);
    rd(2'd3, "t4_set_wins", 2);
    wr(2'd3, 2);
    rd(2'd3, "t4_ecap_clr1", 0);
    expect_val("t4_irq_off", 2, 0);

    // T5: threshold 0 behaves as 1; lowering threshold mid-count
    wr(2'd1, 0);
    in_port = 4'b0000;
    tick(2);
    expect_val("t5_thr0_early", 1, 1);
    tick(1);
    expect_val("t5_thr0_fall", 1, 0);
    rd(2'd3, "t5_ecap", 1);
    wr(2'd3, 32'hF);
    rd(2'd3, "t5_ecap_clr", 0);
    wr(2'd1, 100);
    in_port = 4'b0001;
    tick(51);
    wr(2'd1, 10);
    expect_val("t5_mid_before", 1, 0);
    tick(1);
    expect_val("t5_mid_after", 1, 1);

    // T6: reset mid-count discards counts and captures no edge
    in_port = 4'b1111;
    tick(6);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    expect_val("t6_sw_reset", 1, 0);
    expect_val("t6_irq_reset", 2, 0);
    rd(2'd3, "t6_ecap_reset", 0);
    rd(2'd1, "t6_thr_reset", 500000);
    wr(2'd1, 4);
    tick(2);
    expect_val("t6_sw_early", 1, 0);
    tick(1);
    expect_val("t6_sw_rise", 1, 4'hF);
    rd(2'd3, "t6_ecap", 4'hF);
    rd(2'd0, "t6_data", 4'hF);

    tick(2);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
